sd_cmd_tx: RTL and testbench
============================

SD_CMD_TX -- requirements
Module: sd_cmd_tx

Interface
REQ-001 Parameter: GAP_TICKS, default 8, number of SD-clock ticks the line is held high after the end bit (Ncc); legal range 1..255.
REQ-002 The block SHALL use clock clk and reset reset; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: tx_tick  input  1  one-clk strobe marking the SD-clock falling edge, where CMD data may change.
REQ-006 Port: start  input  1  request to send one command frame.
REQ-007 Port: cmd_index  input  6  command index, sampled when start is accepted.
REQ-008 Port: cmd_arg  input  32  command argument, sampled when start is accepted.
REQ-009 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-010 Port: done  output  1  one-clk pulse at frame completion.
REQ-011 Port: cmd_out  output  1  serial CMD line data.
REQ-012 Port: cmd_oe  output  1  CMD line output enable; 0 = released.

Function
REQ-013 Frame SHALL be 48 bits, sent MSB first: start bit 0, transmission bit 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], end bit 1.
REQ-014 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed serially over frame bits 0..39.
REQ-015 start SHALL be accepted only in IDLE; start while busy SHALL be ignored with no effect on the frame in progress.
REQ-016 FSM states SHALL be IDLE, SEND, GAP; IDLE->SEND on accepted start; SEND->GAP on the tick after bit 47 is driven; GAP->IDLE after GAP_TICKS ticks.
REQ-017 Frame bit k (0..47) SHALL be driven on the (k+1)th tx_tick after acceptance, registered on that clk edge; a tx_tick coincident with the accepting start SHALL NOT count.
REQ-018 cmd_oe SHALL rise with bit 0 and stay high through SEND and GAP.
REQ-019 In GAP, cmd_out SHALL be 1.
REQ-020 On the GAP_TICKS-th tick in GAP: cmd_oe->0, busy->0, done=1 for exactly one clk, state->IDLE.
REQ-021 A start asserted in the same cycle done is high SHALL be accepted.
REQ-022 In IDLE, cmd_out SHALL be 1 and cmd_oe SHALL be 0.
REQ-023 The bit counter SHALL be 6 bits and the gap counter 8 bits; neither SHALL wrap within a frame.
REQ-024 Absent tx_tick, all state SHALL hold indefinitely.

Reset
REQ-025 When reset is asserted: state=IDLE, busy=0, done=0, cmd_out=1, cmd_oe=0, counters and CRC=0, immediately and regardless of the current state.
REQ-026 A frame interrupted by reset SHALL be abandoned; no done pulse SHALL follow.

Configuration
REQ-027 Macro SD_CMD_TX_GAP_EN: when defined, the GAP state SHALL behave per REQ-016/019/020.
REQ-028 When SD_CMD_TX_GAP_EN is undefined: GAP SHALL be omitted, and the tick after bit 47 SHALL release cmd_oe, clear busy and pulse done; GAP_TICKS SHALL be ignored.

Structure
REQ-029 Package sd_pkg SHALL hold the FSM state enum, SD_CMD_FRAME_LEN=48, SD_CRC7_POLY=7'h09.
REQ-030 Sub-module sd_crc7 (clear, enable, serial bit in, 7-bit crc out) SHALL compute CRC7 and be reusable by the response receiver.

Verification
REQ-031 CMD0, arg 0x00000000 -> serial bytes 0x40 00 00 00 00 95, cmd_oe high for 48+8 ticks, one done pulse.
REQ-032 CMD8, arg 0x000001AA -> bytes 0x48 00 00 01 AA 87.
REQ-033 CMD17, arg 0x00000000 -> bytes 0x51 00 00 00 00 55; start pulsed again at bit 20 -> ignored, frame unchanged.
REQ-034 Reset asserted at bit 30 of CMD8 -> cmd_oe=0 and cmd_out=1 the same cycle, no done pulse; the next CMD0 frame is correct.
REQ-035 start coincident with tx_tick, then ticks every 4 clks -> bit 0 appears on the following tick; back-to-back start on the done cycle -> second frame begins on the next tick.
REQ-036 Build without SD_CMD_TX_GAP_EN, CMD0 -> done on tick 49 and cmd_oe low at the same edge.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD command-path definitions: frame geometry, CRC7 polynomial and FSM states.
package sd_pkg;

    localparam int unsigned SD_CMD_FRAME_LEN   = 48;
    localparam int unsigned SD_CMD_PAYLOAD_LEN = 40;
    localparam int unsigned SD_CMD_INDEX_W     = 6;
    localparam int unsigned SD_CMD_ARG_W       = 32;
    localparam int unsigned SD_CRC7_W          = 7;
    localparam logic [SD_CRC7_W-1:0] SD_CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sd_cmd_state_t;

    // CRC-covered leading part of a command frame, MSB transmitted first
    typedef struct packed {
        logic                      start_bit;
        logic                      tx_bit;
        logic [SD_CMD_INDEX_W-1:0] index;
        logic [SD_CMD_ARG_W-1:0]   arg;
    } sd_cmd_payload_t;

    function automatic sd_cmd_payload_t sd_cmd_payload(
        input logic [SD_CMD_INDEX_W-1:0] index,
        input logic [SD_CMD_ARG_W-1:0]   arg
    );
        sd_cmd_payload_t p;
        p.start_bit = 1'b0;
        p.tx_bit    = 1'b1;
        p.index     = index;
        p.arg       = arg;
        return p;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), zero seed; shared by command transmit and response receive.
module sd_crc7
    import sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 din,
    output logic [SD_CRC7_W-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[SD_CRC7_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[SD_CRC7_W-2:0], 1'b0} ^ (fb ? SD_CRC7_POLY : SD_CRC7_W'(0));
        end
    end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD-line frame transmitter: 48-bit command with CRC7, bits advance on tx_tick.
// Optional post-frame Ncc hold enabled by defining SD_CMD_TX_GAP_EN.
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_tick,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        cmd_out,
    output logic        cmd_oe
);

    localparam int unsigned BIT_W = 6;
    localparam int unsigned GAP_W = 8;
    localparam int unsigned PAY_W = SD_CMD_PAYLOAD_LEN;
    localparam logic [BIT_W-1:0] CRC_FIRST = BIT_W'(SD_CMD_PAYLOAD_LEN);
    localparam logic [BIT_W-1:0] END_BIT   = BIT_W'(SD_CMD_FRAME_LEN - 1);
    localparam logic [BIT_W-1:0] CRC_LAST  = BIT_W'(SD_CMD_FRAME_LEN - 2);

    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_gap_range
        $error("sd_cmd_tx: GAP_TICKS must be within 1..255");
    end

    sd_cmd_state_t        state, state_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic [PAY_W-1:0]     shreg, shreg_nxt;
    logic                 busy_nxt, done_nxt, cmd_out_nxt, cmd_oe_nxt;
    logic                 crc_clr, crc_en;
    logic [SD_CRC7_W-1:0] crc;
    logic [2:0]           crc_idx;
`ifdef SD_CMD_TX_GAP_EN
    logic [GAP_W-1:0]     gap_cnt, gap_cnt_nxt;
`endif

    // bit_cnt 40..46 selects crc[6]..crc[0]
    assign crc_idx = 3'(CRC_LAST - bit_cnt);

    sd_crc7 u_crc7 (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clr),
        .enable (crc_en),
        .din    (shreg[PAY_W-1]),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
`ifdef SD_CMD_TX_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            cmd_out <= cmd_out_nxt;
            cmd_oe  <= cmd_oe_nxt;
`ifdef SD_CMD_TX_GAP_EN
            gap_cnt <= gap_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        cmd_out_nxt = cmd_out;
        cmd_oe_nxt  = cmd_oe;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
`ifdef SD_CMD_TX_GAP_EN
        gap_cnt_nxt = gap_cnt;
`endif

        case (state)
            IDLE: begin
                cmd_out_nxt = 1'b1;
                cmd_oe_nxt  = 1'b0;
                // a tick in the accepting cycle is deliberately not a bit slot
                if (start) begin
                    state_nxt   = SEND;
                    busy_nxt    = 1'b1;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = PAY_W'(sd_cmd_payload(cmd_index, cmd_arg));
                    crc_clr     = 1'b1;
                end
            end

            SEND: begin
                if (tx_tick) begin
                    if (bit_cnt < CRC_FIRST) begin
                        cmd_out_nxt = shreg[PAY_W-1];
                        cmd_oe_nxt  = 1'b1;
                        shreg_nxt   = {shreg[PAY_W-2:0], 1'b0};
                        crc_en      = 1'b1;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end else if (bit_cnt <= CRC_LAST) begin
                        cmd_out_nxt = crc[crc_idx];
                        cmd_oe_nxt  = 1'b1;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end else if (bit_cnt == END_BIT) begin
                        cmd_out_nxt = 1'b1;
                        cmd_oe_nxt  = 1'b1;
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end else begin
`ifdef SD_CMD_TX_GAP_EN
                        state_nxt   = GAP;
                        cmd_out_nxt = 1'b1;
                        gap_cnt_nxt = '0;
`else
                        state_nxt   = IDLE;
                        cmd_out_nxt = 1'b1;
                        cmd_oe_nxt  = 1'b0;
                        busy_nxt    = 1'b0;
                        done_nxt    = 1'b1;
`endif
                    end
                end
            end

`ifdef SD_CMD_TX_GAP_EN
            GAP: begin
                cmd_out_nxt = 1'b1;
                if (tx_tick) begin
                    if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                        state_nxt  = IDLE;
                        cmd_oe_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_nxt   = IDLE;
                cmd_out_nxt = 1'b1;
                cmd_oe_nxt  = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: frame contents, timing, ignored start, reset abort, back-to-back.
module tb_sd_cmd_tx;

    localparam int GAP = 8;
`ifdef SD_CMD_TX_GAP_EN
    localparam int EXP_GAP = GAP;
`else
    localparam int EXP_GAP = 0;
`endif
    localparam int DONE_TICK = 49 + EXP_GAP;
    localparam int EXP_OE    = 48 + EXP_GAP;

    localparam logic [47:0] F_CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD17 = 48'h51_0000_0000_55;

    localparam int M_NONE   = 0;
    localparam int M_IGNORE = 1;
    localparam int M_RESET  = 2;
    localparam int M_HOLD   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_tick = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        busy, done, cmd_out, cmd_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    sd_cmd_tx #(.GAP_TICKS(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_tick   (tx_tick),
        .start     (start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .busy      (busy),
        .done      (done),
        .cmd_out   (cmd_out),
        .cmd_oe    (cmd_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // one tx_tick strobe; returns #1 after the edge that consumed it
    task automatic tick();
        @(negedge clk);
        tx_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_tick = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input logic [47:0] exp, input int space, input bit coincide,
                             input bit b2b, input int mode);
        logic [47:0] got;
        int oe_ticks;
        int ticks;
        int bad;
        int dc;
        bit seen;

        @(negedge clk);
        if (b2b) check({tag, "_done_at_start"}, 64'(done), 64'(1));
        start     = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        if (coincide) tx_tick = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        tx_tick   = 1'b0;
        cmd_index = 6'h3F;
        cmd_arg   = 32'hFFFF_FFFF;
        check({tag, "_busy_accept"}, 64'(busy), 64'(1));
        check({tag, "_oe_accept"}, 64'(cmd_oe), 64'(0));
        check({tag, "_done_clear"}, 64'(done), 64'(0));
        idle(space - 1);

        got = '0;
        oe_ticks = 0;
        for (int k = 0; k < 48; k++) begin
            tick();
            got[47-k] = cmd_out;
            if (cmd_oe) oe_ticks++;
            if (k == 0) check({tag, "_oe_bit0"}, 64'(cmd_oe), 64'(1));
            if (mode == M_IGNORE && k == 20) begin
                start     = 1'b1;
                cmd_index = 6'h2A;
                cmd_arg   = 32'h1234_5678;
                @(posedge clk);
                #1;
                start = 1'b0;
                check({tag, "_busy_ignore"}, 64'(busy), 64'(1));
            end
            if (mode == M_HOLD && k == 10) begin
                idle(20);
                #1;
                check({tag, "_hold_out"}, 64'(cmd_out), 64'(exp[37]));
                check({tag, "_hold_oe"}, 64'(cmd_oe), 64'(1));
            end
            if (mode == M_RESET && k == 30) begin
                dc = done_cnt;
                #2;
                reset = 1'b1;
                #1;
                check({tag, "_rst_oe"}, 64'(cmd_oe), 64'(0));
                check({tag, "_rst_out"}, 64'(cmd_out), 64'(1));
                check({tag, "_rst_busy"}, 64'(busy), 64'(0));
                @(negedge clk);
                reset = 1'b0;
                bad = 0;
                for (int j = 0; j < 60; j++) begin
                    tick();
                    if (cmd_oe || done || busy) bad++;
                end
                check({tag, "_abandoned"}, 64'(bad), 64'(0));
                check({tag, "_no_done"}, 64'(done_cnt), 64'(dc));
                return;
            end
            idle(space - 1);
        end
        check({tag, "_bits"}, 64'(got), 64'(exp));

        ticks = 48;
        seen  = 1'b0;
        while (!seen && ticks < 400) begin
            tick();
            ticks++;
            if (cmd_oe) oe_ticks++;
            if (done) seen = 1'b1;
            else begin
                if (cmd_out !== 1'b1) bad++;
                idle(space - 1);
            end
        end
        check({tag, "_done_tick"}, 64'(ticks), 64'(DONE_TICK));
        check({tag, "_oe_ticks"}, 64'(oe_ticks), 64'(EXP_OE));
        check({tag, "_busy_end"}, 64'(busy), 64'(0));
        check({tag, "_out_end"}, 64'(cmd_out), 64'(1));
    endtask

    initial begin
        idle(3);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_out", 64'(cmd_out), 64'(1));
        check("rst_oe", 64'(cmd_oe), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        run_frame("cmd0", 6'd0, 32'h0, F_CMD0, 1, 1'b0, 1'b0, M_NONE);
        idle(3);
        run_frame("cmd8", 6'd8, 32'h1AA, F_CMD8, 3, 1'b0, 1'b0, M_HOLD);
        idle(3);
        run_frame("cmd17", 6'd17, 32'h0, F_CMD17, 2, 1'b0, 1'b0, M_IGNORE);
        idle(3);
        run_frame("cmd8_rst", 6'd8, 32'h1AA, F_CMD8, 1, 1'b0, 1'b0, M_RESET);
        idle(3);
        run_frame("cmd0_post", 6'd0, 32'h0, F_CMD0, 1, 1'b0, 1'b0, M_NONE);
        idle(3);
        run_frame("coinc", 6'd8, 32'h1AA, F_CMD8, 4, 1'b1, 1'b0, M_NONE);
        run_frame("b2b", 6'd17, 32'h0, F_CMD17, 4, 1'b0, 1'b1, M_NONE);
        idle(5);
        #1;
        check("done_pulses", 64'(done_cnt), 64'(6));
        check("idle_oe", 64'(cmd_oe), 64'(0));
        check("idle_out", 64'(cmd_out), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
